// File: rtl/letter_pkg.sv
// letter_pkg: definitions shared by the letter-code scan controller.
//   - letter_t     : 3-bit letter code fed to the shared 7-segment decoder
//   - L_A .. L_P   : letter code constants (A, C, E, F, H, J, L, P = 0..7)
//   - scan_state_t : scan FSM encoding (OFF, GUARD, DRIVE)
package letter_pkg;

    typedef logic [2:0] letter_t;

    localparam letter_t L_A = 3'd0;
    localparam letter_t L_C = 3'd1;
    localparam letter_t L_E = 3'd2;
    localparam letter_t L_F = 3'd3;
    localparam letter_t L_H = 3'd4;
    localparam letter_t L_J = 3'd5;
    localparam letter_t L_L = 3'd6;
    localparam letter_t L_P = 3'd7;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/letter_scan_ctrl_if.sv
// letter_scan_ctrl_if: host-side message buffer write port.
//   wr_en   : write strobe, one entry per cycle
//   wr_addr : buffer entry index
//   wr_data : letter code to store
// Modports: master = host driving writes, slave = scan controller.
interface letter_scan_ctrl_if #(
    parameter int MSG_LEN = 8
);
    import letter_pkg::*;

    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    letter_t       wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/letter_scan_ctrl_tick_gen.sv
// tick_gen: free-running modulo-TICK_DIV counter that marks slot boundaries.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : synchronous clear, holds the count at 0 while high
//   tick       : high on the cycle the count equals TICK_DIV-1
//   tick_early : high on the cycle before a tick (count will be TICK_DIV-1 next)
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_early
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

    logic [CW-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (clear || (count_reg == LAST))
            count_next = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign tick       = (count_reg == LAST);
    // Lets registered outputs line up with the final cycle of a slot.
    assign tick_early = !clear && (count_reg == PRE);

endmodule

// File: rtl/letter_scan_ctrl.sv
// letter_scan_ctrl: time-multiplexed scan controller for DIGITS common-anode
// digits sharing one letter-code decoder. Each digit slot is preceded by a
// blanking guard slot; the visible window optionally scrolls through an
// MSG_LEN-entry message buffer.
//   clk, reset : clock and asynchronous active-high reset
//   en         : display enable (low forces OFF on the next edge)
//   scroll     : advance the window one entry every SCROLL_FRAMES frames
//   wr_bus     : host write port into the message buffer
//   code       : registered letter code for the decoder
//   an         : registered digit enables, active-low
//   frame      : one-cycle pulse on the last cycle of the final digit
module letter_scan_ctrl
    import letter_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int MSG_LEN       = 8,
    parameter int TICK_DIV      = 1000,
    parameter int SCROLL_FRAMES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               scroll,
    letter_scan_ctrl_if.slave  wr_bus,
    output letter_t            code,
    output logic [DIGITS-1:0]  an,
    output logic               frame
);

    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(SCROLL_FRAMES - 1);

    scan_state_t       state_reg, state_next;
    logic [DW-1:0]     digit_reg, digit_next;
    logic [AW-1:0]     base_reg, base_next;
    logic [FW-1:0]     fcnt_reg, fcnt_next;
    letter_t           code_reg, code_next;
    logic [DIGITS-1:0] an_reg, an_next;
    logic              frame_reg, frame_next;
    letter_t           buf_reg [MSG_LEN];

    logic          tick, tick_early, tick_clear;
    logic [AW-1:0] rd_addr;

    // The tick counter only runs while scanning; dropping en clears it on
    // the same edge that moves the FSM to OFF.
    assign tick_clear = (state_reg == OFF) || !en;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .clear      (tick_clear),
        .tick       (tick),
        .tick_early (tick_early)
    );

    // MSG_LEN is a power of two, so the window address wraps for free.
    assign rd_addr = base_reg + AW'(digit_reg);

    // Message buffer: register array so it can take the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++)
                buf_reg[i] <= '0;
        end else if (wr_bus.wr_en) begin
            buf_reg[wr_bus.wr_addr] <= wr_bus.wr_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        base_next  = base_reg;
        fcnt_next  = scroll ? fcnt_reg : '0;
        code_next  = code_reg;
        if (!en) begin
            state_next = OFF;
            digit_next = '0;
            fcnt_next  = '0;
        end else begin
            case (state_reg)
                OFF: state_next = GUARD;
                GUARD: begin
                    if (tick) begin
                        state_next = DRIVE;
                        code_next  = buf_reg[rd_addr];
                    end
                end
                DRIVE: begin
                    if (tick) begin
                        state_next = GUARD;
                        if (digit_reg == LAST_DIGIT) begin
                            // Frame end: a scroll step lands before the next
                            // frame's first load.
                            digit_next = '0;
                            if (scroll) begin
                                if (fcnt_reg == LAST_FRAME) begin
                                    fcnt_next = '0;
                                    base_next = base_reg + 1'b1;
                                end else begin
                                    fcnt_next = fcnt_reg + 1'b1;
                                end
                            end
                        end else begin
                            digit_next = digit_reg + 1'b1;
                        end
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_an
            assign an_next[gi] = !((state_next == DRIVE) && (digit_next == DW'(gi)));
        end
    endgenerate

    assign frame_next = tick_early && (state_reg == DRIVE) && (digit_reg == LAST_DIGIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= OFF;
            digit_reg <= '0;
            base_reg  <= '0;
            fcnt_reg  <= '0;
            code_reg  <= '0;
            an_reg    <= '1;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            digit_reg <= digit_next;
            base_reg  <= base_next;
            fcnt_reg  <= fcnt_next;
            code_reg  <= code_next;
            an_reg    <= an_next;
            frame_reg <= frame_next;
        end
    end

    assign code  = code_reg;
    assign an    = an_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_letter_scan_ctrl.sv
// tb_letter_scan_ctrl: directed bench for letter_scan_ctrl with a time-based
// reference model (cycles since enable -> slot -> digit) checked every cycle,
// plus hand-computed literal expectations at chosen points.
module tb_letter_scan_ctrl;
    import letter_pkg::*;

    localparam int DIGITS    = 4;
    localparam int MSG_LEN   = 8;
    localparam int TD        = 4;
    localparam int SF        = 2;
    localparam int FRAME_LEN = 2 * DIGITS * TD;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic en     = 1'b0;
    logic scroll = 1'b0;
    letter_t           code;
    logic [DIGITS-1:0] an;
    logic              frame;

    letter_scan_ctrl_if #(.MSG_LEN(MSG_LEN)) wr_bus ();

    letter_scan_ctrl #(
        .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .TICK_DIV(TD), .SCROLL_FRAMES(SF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .scroll (scroll),
        .wr_bus (wr_bus),
        .code   (code),
        .an     (an),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: while enabled, m_t counts cycles since entering the
    // first guard slot; slot = m_t/TD, odd slots drive digit (slot/2)%DIGITS.
    letter_t m_buf [MSG_LEN];
    letter_t m_code   = '0;
    bit      m_on     = 1'b0;
    int      m_t      = 0;
    int      m_base   = 0;
    int      m_fsince = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) m_buf[i] = '0;
            m_code = '0; m_on = 1'b0; m_t = 0; m_base = 0; m_fsince = 0;
        end else begin
            if (!en) begin
                m_on = 1'b0; m_t = 0; m_fsince = 0;
            end else if (!m_on) begin
                m_on = 1'b1; m_t = 0;
            end else begin
                if ((m_t + 1) % FRAME_LEN == 0 && scroll) begin
                    m_fsince++;
                    if (m_fsince == SF) begin
                        m_fsince = 0;
                        m_base = (m_base + 1) % MSG_LEN;
                    end
                end
                m_t++;
                if (m_t % TD == 0 && (m_t / TD) % 2 == 1)
                    m_code = m_buf[(m_base + (m_t / TD / 2) % DIGITS) % MSG_LEN];
            end
            if (!scroll) m_fsince = 0;
            if (wr_bus.wr_en) m_buf[wr_bus.wr_addr] = wr_bus.wr_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [DIGITS-1:0] ea;
            logic ef;
            int slot, dig;
            slot = m_t / TD;
            dig  = (slot / 2) % DIGITS;
            ea = '1;
            if (m_on && slot % 2 == 1) ea[dig] = 1'b0;
            ef = m_on && (slot % 2 == 1) && (dig == DIGITS - 1) && (m_t % TD == TD - 1);
            check("model_an", 32'(an), 32'(ea));
            check("model_code", 32'(code), 32'(m_code));
            check("model_frame", 32'(frame), 32'(ef));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the negedge where the model's m_t equals t (cur = -1 right
    // after en is raised at a negedge).
    task automatic goto(input int t);
        repeat (t - cur) @(negedge clk);
        cur = t;
    endtask

    task automatic wr(input int addr, input letter_t data);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = 3'(addr);
        wr_bus.wr_data = data;
        @(negedge clk);
        wr_bus.wr_en   = 1'b0;
    endtask

    task automatic fill_msg();
        letter_t msg [8];
        msg = '{L_A, L_C, L_E, L_F, L_H, L_J, L_L, L_P};
        for (int i = 0; i < MSG_LEN; i++) wr(i, msg[i]);
    endtask

    initial begin
        wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;
        step(3);
        reset = 1'b0;
        $display("txn reset_release");
        check("reset_an", 32'(an), 32'h0000000f);
        check("reset_code", 32'(code), 32'h0);
        check("reset_frame", 32'(frame), 32'h0);

        @(negedge clk);
        fill_msg();
        step(2);
        $display("txn buffer_filled_off");
        check("off_an", 32'(an), 32'h0000000f);

        // Static scan, scroll off.
        en = 1'b1; cur = -1;
        $display("txn scan_static");
        goto(3);  check("guard_an", 32'(an), 32'h0000000f);
        goto(4);  check("d0_an", 32'(an), 32'b1110); check("d0_code", 32'(code), 32'(L_A));
        goto(8);  check("g1_an", 32'(an), 32'h0000000f); check("g1_code", 32'(code), 32'(L_A));
        goto(12); check("d1_an", 32'(an), 32'b1101); check("d1_code", 32'(code), 32'(L_C));
        goto(20); check("d2_an", 32'(an), 32'b1011); check("d2_code", 32'(code), 32'(L_E));
        goto(28); check("d3_an", 32'(an), 32'b0111); check("d3_code", 32'(code), 32'(L_F));
        goto(30); check("frame_pre", 32'(frame), 32'h0);
        goto(31); check("frame_pulse", 32'(frame), 32'h1);
        goto(32); check("frame_post", 32'(frame), 32'h0);
        goto(63); check("frame_pulse2", 32'(frame), 32'h1);
        goto(64);

        en = 1'b0; step(2);
        check("dis_an", 32'(an), 32'h0000000f);

        // Scrolling window, wraps through base 7.
        en = 1'b1; scroll = 1'b1; cur = -1;
        $display("txn scan_scroll");
        goto(68);  check("scr1_d0", 32'(code), 32'(L_C)); check("scr1_an", 32'(an), 32'b1110);
        goto(92);  check("scr1_d3", 32'(code), 32'(L_H));
        goto(452); check("scr7_d0", 32'(code), 32'(L_P));
        goto(460); check("scr7_d1", 32'(code), 32'(L_A));
        goto(468); check("scr7_d2", 32'(code), 32'(L_C));
        goto(476); check("scr7_d3", 32'(code), 32'(L_E)); check("scr7_an", 32'(an), 32'b0111);
        goto(479); check("scr_frame", 32'(frame), 32'h1);

        // Asynchronous reset in the middle of the last drive cycle.
        #2 reset = 1'b1; en = 1'b0; scroll = 1'b0;
        #1;
        $display("txn async_reset");
        check("areset_an", 32'(an), 32'h0000000f);
        check("areset_code", 32'(code), 32'h0);
        check("areset_frame", 32'(frame), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(3);
        check("held_off_an", 32'(an), 32'h0000000f);
        fill_msg();

        // Write to the entry on display: only the next load shows it.
        en = 1'b1; cur = -1;
        $display("txn write_displayed");
        goto(4); check("wd_code0", 32'(code), 32'(L_A));
        wr_bus.wr_en = 1'b1; wr_bus.wr_addr = 3'd0; wr_bus.wr_data = L_P;
        goto(5); wr_bus.wr_en = 1'b0;
        goto(6);  check("wd_code_hold", 32'(code), 32'(L_A));
        goto(36); check("wd_code_new", 32'(code), 32'(L_P)); check("wd_an", 32'(an), 32'b1110);

        // Drop en while digit 2 is lit, then restart.
        $display("txn en_drop");
        goto(53); check("drop_d2_an", 32'(an), 32'b1011);
        en = 1'b0; step(1);
        check("drop_an", 32'(an), 32'h0000000f);
        step(1);
        en = 1'b1; cur = -1;
        goto(3); check("rearm_guard", 32'(an), 32'h0000000f);
        goto(4); check("rearm_an", 32'(an), 32'b1110); check("rearm_code", 32'(code), 32'(L_P));

        // Write on the same edge as the digit-1 load.
        $display("txn write_on_load");
        goto(11);
        wr_bus.wr_en = 1'b1; wr_bus.wr_addr = 3'd1; wr_bus.wr_data = L_L;
        goto(12); wr_bus.wr_en = 1'b0;
        check("wl_old", 32'(code), 32'(L_C)); check("wl_an", 32'(an), 32'b1101);
        goto(44); check("wl_new", 32'(code), 32'(L_L));

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
